rx_control: RTL
===============

// Module: rx_control
// PURPOSE
//  Control FSM for the USB RX path; the receive-side counterpart of the TX control FSM.
//  Sequences sync and PID checks, token/data byte capture and EOP. Pushes data-packet
//  bytes into the shared 64-byte FIFO and reports the packet PID and errors to the AHB
//  slave. Sits between the RX shift register/timer/EOP detector and the data buffer.
// PARAMETERS
//  SYNC_BYTE  8'h80  value rcv_data must hold after the first received byte
//  BUF_DEPTH  64     FIFO capacity in bytes (overflow bound)
//  MAX_BYTES  66     max bytes after the PID in a data packet (64 payload + 2 CRC16)
// PORTS
//  clk                  in   1  system clock
//  n_rst                in   1  asynchronous, active-low reset
//  d_edge               in   1  1-cycle pulse on a D+/D- transition
//  eop                  in   1  SE0 detected (level)
//  shift_enable         in   1  bit-sample strobe from the RX timer
//  byte_received        in   1  1-cycle pulse; rcv_data holds a full byte this cycle
//  rcv_data             in   8  parallel byte from the RX shift register
//  buffer_occupancy     in   7  current FIFO fill (0..64)
//  dev_addr             in   7  device address (only with RX_ADDR_FILTER_EN)
//  rcving               out  1  packet in progress (any state except IDLE)
//  w_enable             out  1  1-cycle FIFO write strobe
//  rx_data              out  8  byte presented to FIFO, valid with w_enable
//  flush                out  1  1-cycle FIFO clear at data-PID accept
//  rx_packet            out  4  last accepted PID, held until the next accept
//  rx_data_ready        out  1  1-cycle pulse: good data packet fully in FIFO
//  rx_transfer_active   out  1  high from d_edge until DONE/ERR completes
//  rx_error             out  1  sticky error flag
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; byte counter 0.
//  Valid PIDs (rcv_data[3:0]; rcv_data[7:4] must equal ~rcv_data[3:0]):
//   token OUT 0001/IN 1001; data DATA0 0011/DATA1 1011; handshake ACK 0010/NAK 1010/STALL 1110.
//  States (Moore outputs unless noted):
//   IDLE      : d_edge -> SYNC_RCV; rx_error cleared on that same d_edge.
//   SYNC_RCV  : byte_received -> SYNC_CHK; eop&shift_enable -> ERR_EOP.
//   SYNC_CHK  : rcv_data==SYNC_BYTE -> PID_RCV, else ERR_EOP.
//   PID_RCV   : byte_received -> PID_CHK; eop&shift_enable -> ERR_EOP.
//   PID_CHK   : bad complement/unknown PID -> ERR_EOP. Otherwise latch rx_packet, cnt=0.
//               data PID: flush=1 -> DATA_RCV; token -> DATA_RCV; handshake -> EOP_WAIT.
//   DATA_RCV  : byte_received -> STORE. eop&shift_enable -> LEN_CHK.
//   STORE     : cnt++. Data packet: w_enable=1, rx_data=rcv_data; if buffer_occupancy==
//               BUF_DEPTH or cnt==MAX_BYTES -> ERR_EOP. Token: no write; cnt==2 -> ERR_EOP.
//               Otherwise -> DATA_RCV.
//   LEN_CHK   : token needs cnt==2; data needs cnt>=2. Pass -> IDLE_WAIT, fail -> ERR_IDLE.
//   EOP_WAIT  : eop&shift_enable -> IDLE_WAIT; byte_received (extra byte) -> ERR_EOP.
//   IDLE_WAIT : d_edge (SE0->J) -> DONE.
//   DONE      : rx_data_ready=1 for data PIDs only -> IDLE.
//   ERR_EOP   : rx_error set; wait eop&shift_enable -> ERR_IDLE.
//   ERR_IDLE  : d_edge -> IDLE.
//  rx_transfer_active = state not in {IDLE, ERR_IDLE}.
//  Latency: byte_received -> w_enable is exactly 1 cycle (STORE is 1 cycle).
//  byte_received and eop in the same cycle: byte_received wins and eop is re-sampled.
//  Reset mid-packet: immediately IDLE with all outputs 0. FIFO contents are not touched.
// CONFIGURATION
//  RX_ADDR_FILTER_EN defined: port dev_addr exists. For tokens, byte1[6:0] is the address.
//   A mismatch at the first token STORE goes to EOP_WAIT (ignore packet: no error,
//   rx_packet restored to its prior value, no flush).
//  Not defined: no dev_addr port; every token is accepted.
// TESTING
//  SYNC 0x80, PID 0xC3 (DATA0), bytes 0x11 0x22 CRC 0xAA 0x55, EOP -> 4 w_enable
//    with those bytes, rx_packet=0011, rx_data_ready 1 pulse after EOP->J edge.
//  SYNC, PID 0xD2 (ACK), EOP -> rx_packet=0010, no w_enable, no rx_data_ready, rx_error=0.
//  SYNC, PID 0xC2 (bad complement) -> rx_error=1 until next packet d_edge, rx_packet unchanged.
//  DATA1 with buffer_occupancy held at 64 on the first byte -> rx_error=1, one w_enable max.
//  SYNC byte 0x81 -> rx_error=1; after EOP and J edge returns to IDLE, rcving=0.
//  Filter on, dev_addr=5: OUT to addr 3 -> ignored, rx_error=0; to addr 5 -> rx_packet=0001.

Source files
------------

// File: rtl/rx_control.sv
// USB RX control FSM: sync/PID checks, token/data byte capture, EOP, FIFO writes and error reporting.
// Optional build macro RX_ADDR_FILTER_EN adds dev_addr and drops tokens addressed elsewhere.
module rx_control #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         BUF_DEPTH = 64,
  parameter int         MAX_BYTES = 66
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic [6:0] buffer_occupancy,
`ifdef RX_ADDR_FILTER_EN
  input  logic [6:0] dev_addr,
`endif
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] rx_data,
  output logic       flush,
  output logic [3:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error
);

  localparam logic [6:0] BUF_FULL = 7'(BUF_DEPTH);
  localparam logic [6:0] MAX_CNT  = 7'(MAX_BYTES);

  localparam logic [1:0] KIND_TOKEN = 2'b01;
  localparam logic [1:0] KIND_DATA  = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    PID_RCV,
    PID_CHK,
    DATA_RCV,
    STORE,
    LEN_CHK,
    EOP_WAIT,
    IDLE_WAIT,
    DONE,
    ERR_EOP,
    ERR_IDLE
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] rx_packet_q, rx_packet_d;
  logic [1:0] kind_q, kind_d;
  logic       rx_error_q, rx_error_d;
  logic [7:0] byte_q, byte_d;
  logic       eop_strobe;
  logic       is_data, is_token;
  logic       ignore_pkt;

  function automatic logic pid_valid(input logic [7:0] b);
    logic known;
    case (b[3:0])
      4'b0001, 4'b1001, 4'b0011, 4'b1011, 4'b0010, 4'b1010, 4'b1110: known = 1'b1;
      default: known = 1'b0;
    endcase
    return known && (b[7:4] == ~b[3:0]);
  endfunction

  assign eop_strobe = eop && shift_enable;
  assign is_data    = (kind_q == KIND_DATA);
  assign is_token   = (kind_q == KIND_TOKEN);

  // The shift register may start refilling after byte_received, so hold the byte locally.
  assign byte_d = byte_received ? rcv_data : byte_q;

`ifdef RX_ADDR_FILTER_EN
  logic [3:0] prev_packet_q, prev_packet_d;
  logic       ignore_q, ignore_d;

  assign ignore_pkt = ignore_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_packet_q <= 4'd0;
      ignore_q      <= 1'b0;
    end else begin
      prev_packet_q <= prev_packet_d;
      ignore_q      <= ignore_d;
    end
  end
`else
  assign ignore_pkt = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 7'd0;
      rx_packet_q <= 4'd0;
      kind_q      <= 2'b00;
      rx_error_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_packet_q <= rx_packet_d;
      kind_q      <= kind_d;
      rx_error_q  <= rx_error_d;
    end
  end

  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_packet_d   = rx_packet_q;
    kind_d        = kind_q;
    rx_error_d    = rx_error_q;
    w_enable      = 1'b0;
    rx_data       = 8'h00;
    flush         = 1'b0;
    rx_data_ready = 1'b0;
`ifdef RX_ADDR_FILTER_EN
    prev_packet_d = prev_packet_q;
    ignore_d      = ignore_q;
`endif

    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d    = SYNC_RCV;
          rx_error_d = 1'b0;
        end
      end
      SYNC_RCV: begin
        if (byte_received)   state_d = SYNC_CHK;
        else if (eop_strobe) state_d = ERR_EOP;
      end
      SYNC_CHK: begin
        state_d = (byte_q == SYNC_BYTE) ? PID_RCV : ERR_EOP;
      end
      PID_RCV: begin
        if (byte_received)   state_d = PID_CHK;
        else if (eop_strobe) state_d = ERR_EOP;
      end
      PID_CHK: begin
        if (!pid_valid(byte_q)) begin
          state_d = ERR_EOP;
        end else begin
          rx_packet_d = byte_q[3:0];
          kind_d      = byte_q[1:0];
          cnt_d       = 7'd0;
`ifdef RX_ADDR_FILTER_EN
          prev_packet_d = rx_packet_q;
          ignore_d      = 1'b0;
`endif
          case (byte_q[1:0])
            KIND_DATA: begin
              flush   = 1'b1;
              state_d = DATA_RCV;
            end
            KIND_TOKEN: state_d = DATA_RCV;
            default:    state_d = EOP_WAIT;
          endcase
        end
      end
      DATA_RCV: begin
        if (byte_received)   state_d = STORE;
        else if (eop_strobe) state_d = LEN_CHK;
      end
      STORE: begin
        cnt_d   = cnt_q + 7'd1;
        state_d = DATA_RCV;
        if (is_data) begin
          w_enable = 1'b1;
          rx_data  = byte_q;
          if ((buffer_occupancy == BUF_FULL) || (cnt_q == MAX_CNT)) state_d = ERR_EOP;
        end else if (is_token) begin
`ifdef RX_ADDR_FILTER_EN
          if ((cnt_q == 7'd0) && (byte_q[6:0] != dev_addr)) begin
            rx_packet_d = prev_packet_q;
            ignore_d    = 1'b1;
            state_d     = EOP_WAIT;
          end else if (cnt_q == 7'd2) begin
            state_d = ERR_EOP;
          end
`else
          if (cnt_q == 7'd2) state_d = ERR_EOP;
`endif
        end
      end
      LEN_CHK: begin
        if (is_token ? (cnt_q == 7'd2) : (cnt_q >= 7'd2)) begin
          state_d = IDLE_WAIT;
        end else begin
          state_d    = ERR_IDLE;
          rx_error_d = 1'b1;
        end
      end
      EOP_WAIT: begin
        // Remaining bytes of an ignored token are expected, not an error.
        if (byte_received) begin
          if (!ignore_pkt) state_d = ERR_EOP;
        end else if (eop_strobe) begin
          state_d = IDLE_WAIT;
        end
      end
      IDLE_WAIT: begin
        if (d_edge) state_d = DONE;
      end
      DONE: begin
        rx_data_ready = is_data && !ignore_pkt;
        state_d       = IDLE;
      end
      ERR_EOP: begin
        rx_error_d = 1'b1;
        if (eop_strobe) state_d = ERR_IDLE;
      end
      ERR_IDLE: begin
        if (d_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rcving             = (state_q != IDLE);
  assign rx_transfer_active = (state_q != IDLE) && (state_q != ERR_IDLE);
  assign rx_packet          = rx_packet_q;
  assign rx_error           = rx_error_q;

endmodule
